// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter: FSM states, port ids, alignment mask.
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StRead  = 2'd2
  } arb_state_e;

  localparam logic PortCpu = 1'b0;
  localparam logic PortDbg = 1'b1;

  localparam logic [31:0] AlignMask = 32'h0000_0003;

  // Word access is legal when 4-aligned and the whole word fits in memory.
  function automatic logic addr_legal(input logic [31:0] addr, input int unsigned mem_bytes);
    return ((addr & AlignMask) == 32'h0) && (addr <= 32'(mem_bytes - 4));
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-request arbiter with one-hot grant. Round-robin by default; DMEM_ARB_FIXED_PRIO_EN makes
// port 0 always win ties and removes the pointer register.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       grant_en,
  output logic [1:0] grant
);

`ifdef DMEM_ARB_FIXED_PRIO_EN

  logic unused_inputs;
  assign unused_inputs = ^{clk, rst_n, grant_en};

  always_comb begin
    grant = 2'b00;
    if (req[0]) begin
      grant = 2'b01;
    end else if (req[1]) begin
      grant = 2'b10;
    end
  end

`else

  // prio_q = 1 means port 1 wins the next tie.
  logic prio_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prio_q <= 1'b0;
    end else if (grant_en && (grant != 2'b00)) begin
      prio_q <= grant[0];
    end
  end

  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = prio_q ? 2'b10 : 2'b01;
    end
  end

`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-ported data memory between the CPU MEM stage (port 0) and debug/loader
// (port 1). Tie policy selected by DMEM_ARB_FIXED_PRIO_EN (see rr_arb2).
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  output logic        p0_ack,
  output logic        p0_err,
  output logic [31:0] p0_rdata,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  output logic        p1_ack,
  output logic        p1_err,
  output logic [31:0] p1_rdata,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        mem_read_enable,
  output logic        mem_write_enable,
  input  logic [31:0] mem_read_data
);

  arb_state_e  state_q, state_d;
  logic        cap_we_q;
  logic        cap_port_q;
  logic [31:0] cap_addr_q;
  logic [31:0] cap_wdata_q;

  logic [1:0]  grant;
  logic        grant_en;
  logic        legal;

  logic        ack;
  logic        err;
  logic [31:0] rdata;
  logic [31:0] addr_out;
  logic [31:0] wdata_out;
  logic        re_out;
  logic        we_out;

  assign grant_en = (state_q == StIdle) && (p0_req || p1_req);
  assign legal    = addr_legal(cap_addr_q, MEM_BYTES);

  rr_arb2 u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      ({p1_req, p0_req}),
    .grant_en (grant_en),
    .grant    (grant)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cap_we_q    <= 1'b0;
      cap_port_q  <= PortCpu;
      cap_addr_q  <= 32'h0;
      cap_wdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      if (grant_en) begin
        cap_port_q  <= grant[1] ? PortDbg : PortCpu;
        cap_we_q    <= grant[1] ? p1_we : p0_we;
        cap_addr_q  <= grant[1] ? p1_addr : p0_addr;
        cap_wdata_q <= grant[1] ? p1_wdata : p0_wdata;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ack       = 1'b0;
    err       = 1'b0;
    rdata     = 32'h0;
    addr_out  = 32'h0;
    wdata_out = 32'h0;
    re_out    = 1'b0;
    we_out    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (grant_en) begin
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (legal) begin
          addr_out  = cap_addr_q;
          wdata_out = cap_wdata_q;
          we_out    = cap_we_q;
          re_out    = !cap_we_q;
          if (cap_we_q) begin
            ack     = 1'b1;
            state_d = StIdle;
          end else begin
            state_d = StRead;
          end
        end else begin
          ack     = 1'b1;
          err     = 1'b1;
          state_d = StIdle;
        end
      end
      StRead: begin
        ack     = 1'b1;
        rdata   = mem_read_data;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Gating with rst_n drops an in-flight transaction: no memory write, no ack.
  assign p0_ack           = rst_n && ack && (cap_port_q == PortCpu);
  assign p1_ack           = rst_n && ack && (cap_port_q == PortDbg);
  assign p0_err           = p0_ack && err;
  assign p1_err           = p1_ack && err;
  assign p0_rdata         = p0_ack ? rdata : 32'h0;
  assign p1_rdata         = p1_ack ? rdata : 32'h0;
  assign mem_address      = rst_n ? addr_out : 32'h0;
  assign mem_write_data   = rst_n ? wdata_out : 32'h0;
  assign mem_read_enable  = rst_n && re_out;
  assign mem_write_enable = rst_n && we_out;

endmodule
